// File: rtl/wb_resp_pkg.sv
// Shared types, widths and the byte-merge helper for the Wishbone register responder.
package wb_resp_pkg;

    localparam int ADR_W    = 11;
    localparam int DAT_W    = 32;
    localparam int IDX_W    = 9;
    localparam int SEL_W    = DAT_W / 8;
    localparam int MAX_WAIT = 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    // Replace byte n of oldVal with byte n of newVal wherever sel[n] is set.
    function automatic logic [DAT_W-1:0] byte_merge(
        input logic [DAT_W-1:0] oldVal,
        input logic [DAT_W-1:0] newVal,
        input logic [SEL_W-1:0] sel
    );
        logic [DAT_W-1:0] res;
        res = oldVal;
        for (int n = 0; n < SEL_W; n++) begin
            if (sel[n]) begin
                res[8*n +: 8] = newVal[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_reg_responder.sv
// Wishbone slave-end responder: byte-writable control registers, one read-only
// status word, configurable wait states and a registered single-cycle ack.
module wb_reg_responder
    import wb_resp_pkg::*;
#(
    parameter int               NREGS       = 8,
    parameter int               WAIT_STATES = 0,
    parameter logic [DAT_W-1:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [DAT_W-1:0]       s_wb_dat_i,
    input  logic [ADR_W-1:0]       s_wb_adr_i,
    input  logic [SEL_W-1:0]       s_wb_sel_i,
    input  logic                   s_wb_we_i,
    input  logic                   s_wb_cyc_i,
    input  logic                   s_wb_stb_i,
    output logic [DAT_W-1:0]       s_wb_dat_o,
    output logic                   s_wb_ack_o,
    output logic [NREGS*DAT_W-1:0] reg_o,
    output logic [NREGS-1:0]       wr_pulse_o,
    output logic [NREGS:0]         rd_pulse_o,
    input  logic [DAT_W-1:0]       sts_i
);

    state_t            r_state;
    state_t            w_next;
    logic              w_req;
    logic              w_enterAck;
    logic [IDX_W-1:0]  r_idx;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [DAT_W-1:0]  r_dat;
    logic [IDX_W-1:0]  w_idx;
    logic              w_we;
    logic [SEL_W-1:0]  w_sel;
    logic [DAT_W-1:0]  w_dat;
    logic [2:0]        r_cnt;
    logic [DAT_W-1:0]  r_regs [NREGS];
    logic              r_ack;
    logic [DAT_W-1:0]  r_rdat;
    logic [NREGS-1:0]  r_wrp;
    logic [NREGS:0]    r_rdp;
    logic              w_unused;

    assign w_req    = s_wb_cyc_i & s_wb_stb_i;
    assign w_unused = ^s_wb_adr_i[1:0];

    // With zero wait states the commit happens on the sampling edge itself,
    // so the live bus fields are used; otherwise the latched copy is.
    assign w_idx = (r_state == IDLE) ? s_wb_adr_i[ADR_W-1:2] : r_idx;
    assign w_we  = (r_state == IDLE) ? s_wb_we_i  : r_we;
    assign w_sel = (r_state == IDLE) ? s_wb_sel_i : r_sel;
    assign w_dat = (r_state == IDLE) ? s_wb_dat_i : r_dat;

    always_comb begin
        w_next     = r_state;
        w_enterAck = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_next     = ACK;
                        w_enterAck = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!s_wb_cyc_i) begin
                    w_next = IDLE;
                end else if (r_cnt == 3'd0) begin
                    w_next     = ACK;
                    w_enterAck = 1'b1;
                end
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_idx <= s_wb_adr_i[ADR_W-1:2];
                r_we  <= s_wb_we_i;
                r_sel <= s_wb_sel_i;
                r_dat <= s_wb_dat_i;
                r_cnt <= 3'(WAIT_STATES - 1);
            end else if (r_state == WAIT && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Register bank and response path; everything here changes only on the
    // edge entering ACK and is cleared again one cycle later.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_ack  <= 1'b0;
            r_rdat <= '0;
            r_wrp  <= '0;
            r_rdp  <= '0;
        end else begin
            r_ack  <= w_enterAck;
            r_rdat <= '0;
            r_wrp  <= '0;
            r_rdp  <= '0;
            if (w_enterAck) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (w_idx == IDX_W'(i)) begin
                        if (w_we) begin
                            r_regs[i] <= byte_merge(r_regs[i], w_dat, w_sel);
                            r_wrp[i]  <= 1'b1;
                        end else begin
                            r_rdat   <= r_regs[i];
                            r_rdp[i] <= 1'b1;
                        end
                    end
                end
                if (!w_we && w_idx == IDX_W'(NREGS)) begin
                    r_rdat       <= sts_i;
                    r_rdp[NREGS] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : gRegOut
        assign reg_o[DAT_W*g +: DAT_W] = r_regs[g];
    end

    assign s_wb_ack_o = r_ack;
    assign s_wb_dat_o = r_rdat;
    assign wr_pulse_o = r_wrp;
    assign rd_pulse_o = r_rdp;

endmodule

// File: tb/tb_wb_reg_responder.sv
// Scoreboard bench for wb_reg_responder: four instances with 0, 2, 3 and 4 wait states.
module tb_wb_reg_responder;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  wrp;
        logic [8:0]  rdp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] sts;
    logic [31:0] dat  [4];
    logic [10:0] adr  [4];
    logic [3:0]  sel  [4];
    logic        we   [4];
    logic        cyc  [4];
    logic        stb  [4];
    logic [31:0] datO [4];
    logic        ack  [4];
    logic [255:0] regO [4];
    logic [7:0]  wrP  [4];
    logic [8:0]  rdP  [4];

    exp_t        sbq[$];
    logic [31:0] model [4][8];
    int          nChecks = 0;
    int          nPass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        wb_reg_responder #(
            .NREGS(8),
            .WAIT_STATES((g == 0) ? 0 : g + 1),
            .RESET_VAL(32'h0000_0000)
        ) u_dut (
            .clk_i(clk), .rst_n(rstN),
            .s_wb_dat_i(dat[g]), .s_wb_adr_i(adr[g]), .s_wb_sel_i(sel[g]),
            .s_wb_we_i(we[g]), .s_wb_cyc_i(cyc[g]), .s_wb_stb_i(stb[g]),
            .s_wb_dat_o(datO[g]), .s_wb_ack_o(ack[g]), .reg_o(regO[g]),
            .wr_pulse_o(wrP[g]), .rd_pulse_o(rdP[g]), .sts_i(sts)
        );
    end

    function automatic int wsOf(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [255:0] packModel(input int k);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = model[k][i];
        return r;
    endfunction

    // One complete transfer on instance k; expectation pushed at drive, popped at ack.
    task automatic xfer(input int k, input logic w, input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   idx;
        int   cnt;
        idx   = int'(a[10:2]);
        e.dat = 32'h0;
        e.wrp = 8'h0;
        e.rdp = 9'h0;
        if (w) begin
            if (idx < 8) begin
                model[k][idx] = mergeBytes(model[k][idx], d, s);
                e.wrp[idx] = 1'b1;
            end
        end else if (idx < 8) begin
            e.dat = model[k][idx];
            e.rdp[idx] = 1'b1;
        end else if (idx == 8) begin
            e.dat = sts;
            e.rdp[8] = 1'b1;
        end
        sbq.push_back(e);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            if (ack[k]) break;
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        e = sbq.pop_front();
        nChecks++;
        if (ack[k] === 1'b1 && cnt == wsOf(k) + 1) nPass++;
        else $display("[TB] FAIL latency inst%0d adr=%h: got ack=%b after %0d cycles, want %0d", k, a, ack[k], cnt, wsOf(k) + 1);
        nChecks++;
        if (datO[k] === e.dat) nPass++;
        else $display("[TB] FAIL dat_o inst%0d adr=%h: got %h, want %h", k, a, datO[k], e.dat);
        nChecks++;
        if (wrP[k] === e.wrp && rdP[k] === e.rdp) nPass++;
        else $display("[TB] FAIL pulses inst%0d adr=%h: got wr=%b rd=%b, want wr=%b rd=%b", k, a, wrP[k], rdP[k], e.wrp, e.rdp);
        nChecks++;
        if (regO[k] === packModel(k)) nPass++;
        else $display("[TB] FAIL reg_o inst%0d adr=%h: got %h, want %h", k, a, regO[k], packModel(k));
        @(posedge clk); #1;
        nChecks++;
        if (ack[k] === 1'b0 && datO[k] === 32'h0 && wrP[k] === 8'h0 && rdP[k] === 9'h0) nPass++;
        else $display("[TB] FAIL ack_drop inst%0d: got ack=%b dat=%h wr=%b rd=%b, want all 0", k, ack[k], datO[k], wrP[k], rdP[k]);
    endtask

    task automatic test_reset();
        logic bad;
        xfer(2, 1'b1, 11'h00C, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 11'h00C; dat[2] = 32'h1111_2222; sel[2] = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0; cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) for (int i = 0; i < 8; i++) model[k][i] = 32'h0;
        nChecks++;
        if (ack[2] === 1'b0 && datO[2] === 32'h0 && regO[2] === 256'h0 && wrP[2] === 8'h0 && rdP[2] === 9'h0) nPass++;
        else $display("[TB] FAIL reset_mid_wait: got ack=%b dat=%h reg=%h wr=%b, want all 0", ack[2], datO[2], regO[2], wrP[2]);
        @(negedge clk);
        rstN = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[2] !== 1'b0 || wrP[2] !== 8'h0) bad = 1'b1;
        end
        nChecks++;
        if (!bad) nPass++;
        else $display("[TB] FAIL reset_no_ack: got late ack/pulse=1, want 0");
        xfer(2, 1'b0, 11'h00C, 32'h0, 4'hF);
    endtask

    task automatic test_write();
        xfer(0, 1'b1, 11'h004, 32'hDEAD_BEEF, 4'b0101);
        nChecks++;
        if (regO[0][63:32] === 32'h00AD_00EF) nPass++;
        else $display("[TB] FAIL reg1_value: got %h, want 00ad00ef", regO[0][63:32]);
        xfer(0, 1'b1, 11'h005, 32'h1122_3344, 4'b1010);
        nChecks++;
        if (regO[0][63:32] === 32'h11AD_33EF) nPass++;
        else $display("[TB] FAIL reg1_merge: got %h, want 11ad33ef", regO[0][63:32]);
        xfer(0, 1'b1, 11'h004, 32'hFFFF_FFFF, 4'b0000);
        xfer(0, 1'b1, 11'h01C, 32'h7654_3210, 4'hF);
    endtask

    task automatic test_read();
        xfer(1, 1'b1, 11'h004, 32'hDEAD_BEEF, 4'b0101);
        xfer(1, 1'b0, 11'h004, 32'h0, 4'h0);
        xfer(0, 1'b0, 11'h004, 32'h0, 4'hF);
        xfer(0, 1'b0, 11'h01C, 32'h0, 4'h1);
    endtask

    task automatic test_status();
        sts = 32'h1234_5678;
        xfer(0, 1'b0, 11'h020, 32'h0, 4'hF);
        xfer(0, 1'b1, 11'h020, 32'hCAFE_BABE, 4'hF);
        sts = 32'h9ABC_DEF0;
        xfer(1, 1'b0, 11'h022, 32'h0, 4'h0);
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 11'h7FC, 32'hFFFF_FFFF, 4'hF);
        xfer(0, 1'b0, 11'h7FC, 32'h0, 4'hF);
        xfer(1, 1'b0, 11'h024, 32'h0, 4'hF);
    endtask

    task automatic test_abort();
        logic bad;
        @(negedge clk);
        cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; adr[3] = 11'h008; dat[3] = 32'hCAFE_F00D; sel[3] = 4'hF;
        bad = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ack[3] !== 1'b0) bad = 1'b1;
        end
        @(negedge clk);
        cyc[3] = 1'b0; stb[3] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[3] !== 1'b0 || wrP[3] !== 8'h0) bad = 1'b1;
        end
        nChecks++;
        if (!bad) nPass++;
        else $display("[TB] FAIL abort_no_ack: got ack or wr_pulse=1, want 0");
        nChecks++;
        if (regO[3][95:64] === model[3][2]) nPass++;
        else $display("[TB] FAIL abort_reg: got %h, want %h", regO[3][95:64], model[3][2]);
        xfer(3, 1'b0, 11'h008, 32'h0, 4'hF);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   t;
        int   prev;
        int   acks;
        for (int j = 0; j < 4; j++) begin
            model[0][4+j] = 32'h1000_0001 * (j + 1);
            e.dat = 32'h0;
            e.wrp = 8'h0;
            e.wrp[4+j] = 1'b1;
            e.rdp = 9'h0;
            sbq.push_back(e);
        end
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        adr[0] = 11'h010; dat[0] = 32'h1000_0001;
        t = 0; prev = 0; acks = 0;
        while (acks < 4 && t < 40) begin
            @(posedge clk); #1;
            t++;
            if (ack[0]) begin
                e = sbq.pop_front();
                nChecks++;
                if (wrP[0] === e.wrp && regO[0][32*(4+acks) +: 32] === model[0][4+acks]) nPass++;
                else $display("[TB] FAIL b2b_write%0d: got wr=%b reg=%h, want wr=%b reg=%h", acks, wrP[0], regO[0][32*(4+acks) +: 32], e.wrp, model[0][4+acks]);
                nChecks++;
                if ((acks == 0 && t == 1) || (acks > 0 && t - prev == 2)) nPass++;
                else $display("[TB] FAIL b2b_spacing%0d: got ack at cycle %0d (prev %0d), want spacing 2", acks, t, prev);
                prev = t;
                acks++;
                if (acks < 4) begin
                    adr[0] = 11'(16 + 4 * acks);
                    dat[0] = 32'h1000_0001 * (acks + 1);
                end else begin
                    cyc[0] = 1'b0; stb[0] = 1'b0;
                end
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        nChecks++;
        if (acks == 4) nPass++;
        else begin
            $display("[TB] FAIL b2b_timeout: got %0d acks, want 4", acks);
            sbq.delete();
        end
        @(posedge clk); #1;
        nChecks++;
        if (regO[0] === packModel(0) && ack[0] === 1'b0) nPass++;
        else $display("[TB] FAIL b2b_final: got reg=%h ack=%b, want reg=%h ack=0", regO[0], ack[0], packModel(0));
    endtask

    initial begin
        rstN = 1'b0;
        sts  = 32'h0;
        for (int k = 0; k < 4; k++) begin
            dat[k] = 32'h0; adr[k] = 11'h0; sel[k] = 4'h0;
            we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
            for (int i = 0; i < 8; i++) model[k][i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (ack[k] === 1'b0 && datO[k] === 32'h0 && regO[k] === 256'h0 && wrP[k] === 8'h0 && rdP[k] === 9'h0) nPass++;
            else $display("[TB] FAIL reset_state inst%0d: got ack=%b dat=%h reg=%h, want all 0", k, ack[k], datO[k], regO[k]);
        end
        @(negedge clk);
        rstN = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_status();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
